// File: rtl/mdu_pkg.sv
// Shared encodings, widths and helpers for the multiply/HI-LO control stage.
// MDU_SIGNED_EN selects whether abs_w() is used for signed MULT conditioning.
package mdu_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // 0x80000000 stays 0x80000000, which is the correct unsigned magnitude 2^31.
    function automatic logic [MUL_W-1:0] abs_w(input logic [MUL_W-1:0] v);
        return v[MUL_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_hilo_reg.sv
// HI/LO architectural register pair: independent HI and LO writes plus a
// joint 64-bit write used for multiply write-back.
module hilo_reg
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [MUL_W-1:0]  wdata,
    input  logic              we_pair,
    input  logic [PROD_W-1:0] pair_data,
    output logic [MUL_W-1:0]  hi,
    output logic [MUL_W-1:0]  lo
);

    logic [MUL_W-1:0] r_hi;
    logic [MUL_W-1:0] r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (we_pair) begin
            {r_hi, r_lo} <= pair_data;
        end else begin
            if (we_hi) r_hi <= wdata;
            if (we_lo) r_lo <= wdata;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/HI-LO control stage: decodes MDU ops, drives the iterative
// multiplier, commits HI/LO and stalls on hazards. Macro: MDU_SIGNED_EN.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [MUL_W-1:0]  rs_val,
    input  logic [MUL_W-1:0]  rt_val,
    input  logic              flush,
    output logic              mul_start,
    output logic [MUL_W-1:0]  mul_a,
    output logic [MUL_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_z,
    input  logic              mul_busy,
    output logic [MUL_W-1:0]  hi,
    output logic [MUL_W-1:0]  lo,
    output logic              stall,
    output logic              done
);

    state_t           r_state;
    logic [MUL_W-1:0] r_mul_a;
    logic [MUL_W-1:0] r_mul_b;
    logic             r_mul_start;
    logic             r_done;

    logic              w_accept;
    logic              w_is_mul;
    logic [MUL_W-1:0]  w_a;
    logic [MUL_W-1:0]  w_b;
    logic              w_we_pair;
    logic [PROD_W-1:0] w_pair_data;

    // Flush kills any request presented in the same cycle.
    assign w_accept = req_valid && !flush && (r_state == ST_IDLE);
    assign w_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);

`ifdef MDU_SIGNED_EN
    logic w_signed;
    logic w_neg;
    logic r_neg;

    assign w_signed = (req_op == OP_MULT);
    assign w_a      = w_signed ? abs_w(rs_val) : rs_val;
    assign w_b      = w_signed ? abs_w(rt_val) : rt_val;
    assign w_neg    = w_signed && (rs_val[MUL_W-1] ^ rt_val[MUL_W-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_neg <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_neg <= w_neg;
        end
    end

    assign w_pair_data = r_neg ? (~mul_z + 64'd1) : mul_z;
`else
    assign w_a         = rs_val;
    assign w_b         = rt_val;
    assign w_pair_data = mul_z;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            r_done      <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_valid && w_is_mul) begin
                            r_mul_a     <= w_a;
                            r_mul_b     <= w_b;
                            r_mul_start <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end
                    ST_START: r_state <= ST_WAIT;
                    // Busy is registered in the multiplier and already high here.
                    ST_WAIT: begin
                        if (!mul_busy) r_state <= ST_WB;
                    end
                    ST_WB: begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_we_pair = (r_state == ST_WB) && !flush;

    hilo_reg u_hilo_reg (
        .clk       (clk),
        .reset     (reset),
        .we_hi     (w_accept && (req_op == OP_MTHI)),
        .we_lo     (w_accept && (req_op == OP_MTLO)),
        .wdata     (rs_val),
        .we_pair   (w_we_pair),
        .pair_data (w_pair_data),
        .hi        (hi),
        .lo        (lo)
    );

    assign stall     = (r_state != ST_IDLE) && req_valid && (req_op != OP_NOP);
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign done      = r_done;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of MULT/MULTU/MTHI/MTLO vectors plus
// hazard, flush and mid-multiply reset sequences, with a behavioural multiplier.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = OP_NOP;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_z;
    logic        mul_busy;
    logic [31:0] hi, lo;
    logic        stall, done;

    int n_cmp = 0;
    int n_err = 0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_z(mul_z), .mul_busy(mul_busy),
        .hi(hi), .lo(lo), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    // Unsigned iterative multiplier: busy spans 31 cycles after the start pulse,
    // so the controller reaches WB in T+34 and commits for T+35.
    int m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy <= 1'b0;
            m_cnt    <= 0;
            mul_z    <= '0;
        end else if (mul_start) begin
            mul_z    <= {32'b0, mul_a} * {32'b0, mul_b};
            m_cnt    <= 31;
            mul_busy <= 1'b1;
        end else if (m_cnt > 0) begin
            m_cnt    <= m_cnt - 1;
            mul_busy <= (m_cnt > 1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    // Presents one request in cycle T and checks the result at its commit cycle.
    task automatic run_vec(input int idx, input vec_t v);
        step();
        req_valid = 1'b1; req_op = v.op; rs_val = v.a; rt_val = v.b;
        mid();
        chk($sformatf("v%0d_stall_idle", idx), {63'b0, stall}, 64'd0);
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        mid();
        if (v.op == OP_MULT || v.op == OP_MULTU) begin
            chk($sformatf("v%0d_start_t1", idx), {63'b0, mul_start}, 64'd1);
            for (int k = 2; k <= 34; k++) begin
                step(); mid();
                chk($sformatf("v%0d_done_early_t%0d", idx, k), {63'b0, done}, 64'd0);
            end
            step(); mid();
            chk($sformatf("v%0d_done_t35", idx), {63'b0, done}, 64'd1);
        end
        chk($sformatf("v%0d_hi", idx), {32'b0, hi}, {32'b0, v.exp_hi});
        chk($sformatf("v%0d_lo", idx), {32'b0, lo}, {32'b0, v.exp_lo});
        $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h", idx, v.op, v.a, v.b, hi, lo);
        step(); mid();
        chk($sformatf("v%0d_done_once", idx), {63'b0, done}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
`ifdef MDU_SIGNED_EN
        vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[3] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
`else
        vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vecs[3] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFB, 32'h00000006, 32'hFFFFFFDD};
        vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
`endif
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{OP_MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000};
        vecs[6] = '{OP_MTLO,  32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D};

        // Reset state
        #2;
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_start", {63'b0, mul_start}, 64'd0);
        step(); step();
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // MFLO hazard: MULTU 6x7 with MFLO presented from T+5
        step();
        req_valid = 1'b1; req_op = OP_MULTU; rs_val = 32'd6; rt_val = 32'd7;
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        for (int k = 2; k <= 4; k++) step();
        mid();
        chk("haz_nomdu_nostall", {63'b0, stall}, 64'd0);
        for (int k = 5; k <= 34; k++) begin
            if (k > 5) step();
            req_valid = 1'b1; req_op = OP_MFLO;
            mid();
            chk($sformatf("haz_stall_t%0d", k), {63'b0, stall}, 64'd1);
        end
        step(); mid();
        chk("haz_stall_t35", {63'b0, stall}, 64'd0);
        chk("haz_lo_t35", {32'b0, lo}, 64'd42);
        chk("haz_done_t35", {63'b0, done}, 64'd1);
        $display("hazard mflo read lo=%h", lo);
        step();
        req_valid = 1'b0; req_op = OP_NOP;

        // Flush mid-multiply: hi=0 lo=42 must survive
        step();
        req_valid = 1'b1; req_op = OP_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'd2;
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        for (int k = 2; k <= 10; k++) step();
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MTLO; rs_val = 32'hAAAAAAAA;
        step();
        flush = 1'b0; req_op = OP_MFHI;
        mid();
        chk("flush_idle_t11", {63'b0, stall}, 64'd0);
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        for (int k = 0; k < 30; k++) begin
            mid();
            chk($sformatf("flush_no_done_%0d", k), {63'b0, done}, 64'd0);
            step();
        end
        mid();
        chk("flush_hi_kept", {32'b0, hi}, 64'd0);
        chk("flush_lo_kept", {32'b0, lo}, 64'd42);
        $display("flush result hi=%h lo=%h", hi, lo);
        step();
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MTLO; rs_val = 32'h55555555;
        step();
        flush = 1'b0; req_valid = 1'b0; req_op = OP_NOP;
        mid();
        chk("flush_drops_mtlo", {32'b0, lo}, 64'd42);
        step();
        req_valid = 1'b1; req_op = OP_MTHI; rs_val = 32'h12345678;
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        mid();
        chk("mthi_after_flush", {32'b0, hi}, 64'h12345678);
        $display("mthi after flush hi=%h", hi);

        // Reset mid-multiply at T+20
        step();
        req_valid = 1'b1; req_op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9;
        step();
        req_valid = 1'b0; req_op = OP_NOP;
        for (int k = 2; k <= 20; k++) step();
        req_valid = 1'b1; req_op = OP_MFHI;
        #1;
        chk("pre_rst_stall", {63'b0, stall}, 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        chk("midrst_stall", {63'b0, stall}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_start", {63'b0, mul_start}, 64'd0);
        $display("mid-multiply reset hi=%h lo=%h stall=%b", hi, lo, stall);
        step(); step();
        req_valid = 1'b0; req_op = OP_NOP;
        reset = 1'b1;
        run_vec(8, '{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
